// File: rtl/uart_rx_fifo_if.sv
// Signal bundle between the UART receive front end and the register block.
// slave = receiver side, master = register block / test driver side.
interface uart_rx_fifo_if #(
    parameter int CNT_W = 4
);
    logic             rx_in;
    logic             rd_en;
    logic             clr_err;
    logic [7:0]       data_out;
    logic             rx_valid;
    logic [CNT_W-1:0] fifo_count;
    logic             overrun;
    logic             frame_err;
    logic             parity_err;
    logic [2:0]       dbg_state;

    // Pop handshake: data_out is valid while rx_valid=1; a cycle with
    // rd_en=1 and rx_valid=1 consumes the head byte at the next clk edge,
    // rd_en with rx_valid=0 has no effect.
    modport slave (
        input  rx_in, rd_en, clr_err,
        output data_out, rx_valid, fifo_count, overrun, frame_err, parity_err, dbg_state
    );

    modport master (
        output rx_in, rd_en, clr_err,
        input  data_out, rx_valid, fifo_count, overrun, frame_err, parity_err, dbg_state
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a first-word-fall-through byte FIFO with sticky errors.
// Optional even parity bit when UART_RX_PARITY_EN is defined.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 347,
    parameter int FIFO_DEPTH   = 8,
    parameter int CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic           clk,
    input  logic           rst,
    uart_rx_fifo_if.slave  bus
);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int AW     = CNT_W - 1;
    localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BAUD_W-1:0] FULL_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
`ifdef UART_RX_PARITY_EN
        ,
        PARITY    = 3'd5
`endif
    } state_t;

    logic [1:0]        sync_q;
    logic              rx_s;

    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              push_q, push_d;
    logic              frame_set;
    logic              parity_set;

    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [CNT_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic              empty, full, pop, do_push, ovf_set;
    logic              overrun_q, frame_err_q, parity_err_q;

    assign rx_s = sync_q[1];

    always_ff @(posedge clk) begin
        if (rst) sync_q <= 2'b11;
        else     sync_q <= {sync_q[0], bus.rx_in};
    end

`ifdef UART_RX_PARITY_EN
    logic par_bad_q, par_bad_d;

    always_ff @(posedge clk) begin
        if (rst) par_bad_q <= 1'b0;
        else     par_bad_q <= par_bad_d;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            push_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            push_q  <= push_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q + BAUD_W'(1);
        bit_d      = bit_q;
        shift_d    = shift_q;
        push_d     = 1'b0;
        frame_set  = 1'b0;
        parity_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d  = par_bad_q;
`endif
        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (!rx_s) state_d = START;
            end
            START: begin
                if (baud_q == HALF_LAST) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (baud_q == FULL_LAST) begin
                    baud_d  = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                // Even parity: data bits plus parity bit hold an even number of ones.
                if (baud_q == FULL_LAST) begin
                    baud_d     = '0;
                    par_bad_d  = (rx_s != ^shift_q);
                    parity_set = (rx_s != ^shift_q);
                    state_d    = STOP;
                end
            end
`endif
            STOP: begin
                if (baud_q == FULL_LAST) begin
                    baud_d = '0;
                    if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                        push_d = !par_bad_q;
`else
                        push_d = 1'b1;
`endif
                        state_d = IDLE;
                    end else begin
                        frame_set = 1'b1;
                        state_d   = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                // A held-low line (break) must not look like a new start bit.
                baud_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: begin
                baud_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    // shift_q stays stable for a full bit time after the stop sample, so the
    // registered push can take its byte straight from the shifter.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop     = bus.rd_en && !empty;
    assign do_push = push_q && (!full || pop);
    assign ovf_set = push_q && full && !pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
                wr_ptr_q                <= wr_ptr_q + CNT_W'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + CNT_W'(1);
        end
    end

    // A new error event takes priority over a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            overrun_q    <= (overrun_q    && !bus.clr_err) || ovf_set;
            frame_err_q  <= (frame_err_q  && !bus.clr_err) || frame_set;
            parity_err_q <= (parity_err_q && !bus.clr_err) || parity_set;
        end
    end

    assign bus.data_out   = mem_q[rd_ptr_q[AW-1:0]];
    assign bus.rx_valid   = !empty;
    assign bus.fifo_count = wr_ptr_q - rd_ptr_q;
    assign bus.overrun    = overrun_q;
    assign bus.frame_err  = frame_err_q;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = parity_err_q;
`else
    assign bus.parity_err = 1'b0;
`endif
    assign bus.dbg_state  = state_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo with CLKS_PER_BIT=16, FIFO_DEPTH=4; scoreboard of expected bytes.
module tb_uart_rx_fifo;
    localparam int N     = 16;
    localparam int DEPTH = 4;
    localparam int CW    = 3;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 171;
`else
    localparam int LAT = 155;
`endif
    localparam int STOP_EDGE = LAT - 1;
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   lat_seen;
    logic [7:0] exp_q[$];

    uart_rx_fifo_if #(.CNT_W(CW)) bus ();

    uart_rx_fifo #(
        .CLKS_PER_BIT(N),
        .FIFO_DEPTH  (DEPTH),
        .CNT_W       (CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Drives one frame starting at a negedge; returns at a negedge with the line idle.
    task automatic send_frame(input logic [7:0] d, input logic par_bit, input logic stop_bit);
        bus.rx_in = 1'b0;
        repeat (N) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.rx_in = d[i];
            repeat (N) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        bus.rx_in = par_bit;
        repeat (N) @(negedge clk);
`endif
        bus.rx_in = stop_bit;
        repeat (N) @(negedge clk);
        bus.rx_in = 1'b1;
    endtask

    task automatic send_good(input logic [7:0] d);
        send_frame(d, ^d, 1'b1);
    endtask

    // Scoreboard consumer: compares the head byte, then pops it.
    task automatic pop_check(input string name);
        logic [7:0] exp;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, data_out=%h rx_valid=%b", name, bus.data_out, bus.rx_valid);
        end else begin
            exp = exp_q.pop_front();
            if (bus.rx_valid !== 1'b1 || bus.data_out !== exp) begin
                errors++;
                $display("FAIL %s: rx_valid=%b data_out=%h, expected rx_valid=1 data_out=%h",
                         name, bus.rx_valid, bus.data_out, exp);
            end
        end
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.rx_valid !== 1'b0 || bus.fifo_count !== 3'd0 || bus.data_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_fifo: rx_valid=%b count=%0d data_out=%h, expected 0/0/00",
                     bus.rx_valid, bus.fifo_count, bus.data_out);
        end
        checks++;
        if (bus.overrun !== 1'b0 || bus.frame_err !== 1'b0 || bus.parity_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: ovr=%b fe=%b pe=%b, expected 0/0/0",
                     bus.overrun, bus.frame_err, bus.parity_err);
        end
        checks++;
        if (bus.dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_state: state=%0d, expected %0d", bus.dbg_state, ST_IDLE);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        bus.rx_in = 1'b0;
        repeat (5 * N) @(negedge clk);
        bus.rx_in = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (12 * N) @(negedge clk);
        checks++;
        if (bus.fifo_count !== 3'd0 || bus.dbg_state !== ST_IDLE || bus.frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_frame: count=%0d state=%0d fe=%b, expected 0/%0d/0",
                     bus.fifo_count, bus.dbg_state, bus.frame_err, ST_IDLE);
        end
    endtask

    task automatic test_single();
        exp_q.push_back(8'hA5);
        lat_seen = -1;
        fork
            send_good(8'hA5);
            begin
                for (int k = 0; k < 400 && lat_seen < 0; k++) begin
                    @(posedge clk);
                    #1;
                    if (bus.rx_valid === 1'b1) lat_seen = k;
                end
            end
        join
        checks++;
        if (lat_seen != LAT) begin
            errors++;
            $display("FAIL single_latency: rx_valid rose at edge %0d, expected %0d", lat_seen, LAT);
        end
        checks++;
        if (bus.fifo_count !== 3'd1) begin
            errors++;
            $display("FAIL single_count: count=%0d, expected 1", bus.fifo_count);
        end
        pop_check("single_data");
        checks++;
        if (bus.rx_valid !== 1'b0 || bus.fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL single_drain: rx_valid=%b count=%0d, expected 0/0", bus.rx_valid, bus.fifo_count);
        end
    endtask

    task automatic test_glitch();
        bus.rx_in = 1'b0;
        repeat (3) @(negedge clk);
        bus.rx_in = 1'b1;
        repeat (3 * N) @(negedge clk);
        checks++;
        if (bus.fifo_count !== 3'd0 || bus.dbg_state !== ST_IDLE ||
            bus.frame_err !== 1'b0 || bus.overrun !== 1'b0) begin
            errors++;
            $display("FAIL glitch: count=%0d state=%0d fe=%b ovr=%b, expected 0/%0d/0/0",
                     bus.fifo_count, bus.dbg_state, bus.frame_err, bus.overrun, ST_IDLE);
        end
    endtask

    task automatic test_empty_pop();
        bus.rd_en = 1'b1;
        repeat (2) @(negedge clk);
        bus.rd_en = 1'b0;
        checks++;
        if (bus.fifo_count !== 3'd0 || bus.rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL empty_pop: count=%0d rx_valid=%b, expected 0/0", bus.fifo_count, bus.rx_valid);
        end
    endtask

    task automatic test_overrun();
        logic [7:0] b;
        for (int i = 1; i <= 4; i++) begin
            b = 8'(i * 8'h11);
            exp_q.push_back(b);
            send_good(b);
        end
        checks++;
        if (bus.fifo_count !== 3'd4 || bus.overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_fill: count=%0d ovr=%b, expected 4/0", bus.fifo_count, bus.overrun);
        end
        send_good(8'h55);
        checks++;
        if (bus.fifo_count !== 3'd4 || bus.overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set: count=%0d ovr=%b, expected 4/1", bus.fifo_count, bus.overrun);
        end
        for (int i = 0; i < 4; i++) pop_check("overrun_order");
        bus.clr_err = 1'b1;
        @(negedge clk);
        bus.clr_err = 1'b0;
        checks++;
        if (bus.overrun !== 1'b0 || bus.fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL overrun_clear: ovr=%b count=%0d, expected 0/0", bus.overrun, bus.fifo_count);
        end
    endtask

    task automatic test_frame_err();
        fork
            send_frame(8'h3C, ^8'h3C, 1'b0);
            begin
                // clr_err lands on the same edge that samples the bad stop bit.
                repeat (STOP_EDGE) @(negedge clk);
                bus.clr_err = 1'b1;
                @(negedge clk);
                bus.clr_err = 1'b0;
            end
        join
        bus.rx_in = 1'b0;
        repeat (40) @(negedge clk);
        checks++;
        if (bus.frame_err !== 1'b1 || bus.dbg_state !== ST_WAIT_HIGH || bus.fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL frame_err_set: fe=%b state=%0d count=%0d, expected 1/%0d/0",
                     bus.frame_err, bus.dbg_state, bus.fifo_count, ST_WAIT_HIGH);
        end
        bus.rx_in = 1'b1;
        repeat (N) @(negedge clk);
        exp_q.push_back(8'h7E);
        send_good(8'h7E);
        checks++;
        if (bus.fifo_count !== 3'd1 || bus.frame_err !== 1'b1) begin
            errors++;
            $display("FAIL frame_err_next: count=%0d fe=%b, expected 1/1", bus.fifo_count, bus.frame_err);
        end
        pop_check("frame_err_data");
        bus.clr_err = 1'b1;
        @(negedge clk);
        bus.clr_err = 1'b0;
        checks++;
        if (bus.frame_err !== 1'b0) begin
            errors++;
            $display("FAIL frame_err_clear: fe=%b, expected 0", bus.frame_err);
        end
    endtask

    task automatic test_full_pop_push();
        logic [7:0] exp;
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back(8'hA0 + 8'(i));
            send_good(8'hA0 + 8'(i));
        end
        fork
            send_good(8'h99);
            begin
                repeat (LAT) @(negedge clk);
                checks++;
                exp = exp_q.pop_front();
                if (bus.data_out !== exp) begin
                    errors++;
                    $display("FAIL full_pop_head: data_out=%h, expected %h", bus.data_out, exp);
                end
                exp_q.push_back(8'h99);
                bus.rd_en = 1'b1;
                @(negedge clk);
                bus.rd_en = 1'b0;
            end
        join
        checks++;
        if (bus.fifo_count !== 3'd4 || bus.overrun !== 1'b0) begin
            errors++;
            $display("FAIL full_pop_push: count=%0d ovr=%b, expected 4/0", bus.fifo_count, bus.overrun);
        end
        for (int i = 0; i < 4; i++) pop_check("full_pop_order");
    endtask

    task automatic test_back_to_back();
        logic [7:0] b;
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            send_good(b);
        end
        checks++;
        if (bus.fifo_count !== 3'd3) begin
            errors++;
            $display("FAIL b2b_count: count=%0d, expected 3", bus.fifo_count);
        end
        for (int i = 0; i < 3; i++) pop_check("b2b_data");
    endtask

    task automatic test_parity();
`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b0, 1'b1);
        checks++;
        if (bus.parity_err !== 1'b1 || bus.fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL parity_bad: pe=%b count=%0d, expected 1/0", bus.parity_err, bus.fifo_count);
        end
        bus.clr_err = 1'b1;
        @(negedge clk);
        bus.clr_err = 1'b0;
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b1);
        checks++;
        if (bus.parity_err !== 1'b0 || bus.fifo_count !== 3'd1) begin
            errors++;
            $display("FAIL parity_good: pe=%b count=%0d, expected 0/1", bus.parity_err, bus.fifo_count);
        end
        pop_check("parity_data");
`else
        checks++;
        if (bus.parity_err !== 1'b0) begin
            errors++;
            $display("FAIL parity_tied: pe=%b, expected 0", bus.parity_err);
        end
`endif
    endtask

    initial begin
        bus.rx_in   = 1'b1;
        bus.rd_en   = 1'b0;
        bus.clr_err = 1'b0;
        @(negedge clk);
        test_reset();
        test_reset_mid_frame();
        test_single();
        test_glitch();
        test_empty_pop();
        test_overrun();
        test_frame_err();
        test_full_pop_push();
        test_back_to_back();
        test_parity();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: %0d bytes never observed", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
